link_partner: RTL and testbench
===============================

LINK_PARTNER -- requirements
Module: link_partner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 64: clk cycles per SCK half-period in master mode, minimum 4.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF: byte shifted out when no tx byte is pending.
REQ-003 SHALL have parameter TIMEOUT, default 4096: clk cycles without an SCK edge mid-byte before the transfer aborts.
REQ-004 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port master, input, 1: 1 = this block drives SCK; 0 = follows the DMG-driven SCK; sampled only in IDLE.
REQ-007 Port sck_in, input, 1: link SCK as driven by the DMG; asynchronous to clk.
REQ-008 Port sck_out, output, 1: generated SCK, valid when sck_oe=1.
REQ-009 Port sck_oe, output, 1: high while master=1 and the state is not IDLE.
REQ-010 Port so_in, input, 1: DMG serial out (SO), asynchronous.
REQ-011 Port si_out, output, 1: drives DMG serial in (SI).
REQ-012 Port tx_data, input, 8: byte to send.
REQ-013 Port tx_valid, input, 1 and port tx_ready, output, 1: valid/ready handshake; transfer occurs when both are high on a clk edge.
REQ-014 Port rx_data, output, 8 and port rx_valid, output, 1: received byte plus a one-cycle strobe.
REQ-015 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 sck_in and so_in SHALL pass through two-flop synchronizers; edge detection SHALL use the synchronized SCK; so_in SHALL be sampled from its synchronized value.
REQ-017 SHALL hold a one-entry tx buffer; tx_ready=1 when empty; accepting tx_data fills the buffer.
REQ-018 SHALL implement FSM IDLE -> SHIFT -> IDLE with a 3-bit bit counter.
REQ-019 In IDLE, si_out SHALL equal bit 7 of the buffer if full, else IDLE_BYTE[7].
REQ-020 Slave mode: the first SCK falling edge in IDLE SHALL latch the buffer (or IDLE_BYTE) into the tx shift register, mark the buffer empty, and enter SHIFT.
REQ-021 In SHIFT, each SCK rising edge SHALL shift so_in into the rx shift register LSB and increment the counter; each falling edge SHALL advance si_out to the next bit, MSB first.
REQ-022 On the 8th rising edge, rx_data SHALL update and rx_valid SHALL pulse for exactly 1 cycle, 3 clk cycles after the raw sck_in edge; the FSM SHALL then return to IDLE.
REQ-023 Master mode: leaving IDLE SHALL require a full buffer; SCK SHALL start high, fall after CLK_DIV cycles, and toggle every CLK_DIV cycles for 8 low/high periods.
REQ-024 In master mode, the internal sck_out edges SHALL drive the shift logic of REQ-021 directly, with no synchronizer delay.
REQ-025 In slave SHIFT, if TIMEOUT cycles pass with no SCK edge, the FSM SHALL return to IDLE, discard partial rx data, and not assert rx_valid.
REQ-026 If tx_valid arrives while the buffer is empty during SHIFT, the byte SHALL be accepted and held for the next transfer.
REQ-027 mode change (master) during SHIFT SHALL be ignored until IDLE.

Reset
REQ-028 On reset: state IDLE, counter 0, buffer empty, tx_ready=1, rx_valid=0, rx_data=8'h00, si_out=IDLE_BYTE[7], sck_out=1, sck_oe=0, busy=0, synchronizers=1; reset mid-transfer SHALL abandon the transfer without asserting rx_valid.

Structure
REQ-029 The link_pkg shared package SHALL hold the state enum type and the 8-bit link_byte_t typedef.
REQ-030 A sub-module sync2 SHALL implement the two-flop synchronizer and SHALL be instantiated twice.

Verification
REQ-031 Slave mode, buffer=8'hA5, DMG clocks 8'h3C at a 200-clk half-period -> si_out bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; one rx_valid pulse.
REQ-032 Slave mode, no buffer, DMG sends 8'h00 -> partner sends 8'hFF; rx_data=8'h00.
REQ-033 Master mode, CLK_DIV=4, buffer=8'h81, so_in tied to 0 -> 8 SCK periods of 8 clk each; rx_valid pulse; busy low afterwards; tx_ready high.
REQ-034 Slave mode, stop SCK after 3 bits for 5000 cycles -> back to IDLE, no rx_valid; next full byte is received correctly.
REQ-035 Assert reset after bit 5 of a transfer -> all outputs at reset values next cycle; no rx_valid.
REQ-036 Offer tx_valid during SHIFT with an empty buffer -> accepted immediately; the byte is sent on the following transfer.

Source files
------------

// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : link_pkg
//  Description : Shared types for the link-port partner. Holds the transfer
//                state enum, the byte type and the bits-per-byte constant.
//  Revision    : 1.0  initial release
// ============================================================================
package link_pkg;

    // Bits shifted per link transfer.
    localparam int LINK_BITS = 8;

    typedef logic [7:0] link_byte_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } link_state_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a single asynchronous input.
//                Both flops load RESET_VAL on reset so the output starts
//                at the line's idle level.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                d     - asynchronous input
//                q     - synchronized output
//  Revision    : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/link_partner.sv
`default_nettype none
// ============================================================================
//  Module      : link_partner
//  Description : Serial link partner for a DMG link port. Exchanges one byte
//                per transfer, MSB first, either following the DMG clock
//                (slave) or generating SCK itself (master). A one-entry tx
//                buffer is filled through a valid/ready handshake; received
//                bytes are presented with a one-cycle rx_valid strobe.
//  Ports       : clk, reset          - system clock, sync active-high reset
//                master              - 1 = generate SCK, 0 = follow sck_in
//                sck_in / so_in      - DMG SCK and SO (asynchronous)
//                sck_out / sck_oe    - generated SCK and its output enable
//                si_out              - drives DMG SI
//                tx_data/valid/ready - byte to send, handshake
//                rx_data / rx_valid  - received byte and strobe
//                busy                - transfer in progress
//  Revision    : 1.0  initial release
// ============================================================================
module link_partner
    import link_pkg::*;
#(
    parameter int         CLK_DIV   = 64,
    parameter link_byte_t IDLE_BYTE = 8'hFF,
    parameter int         TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       master,
    input  logic       sck_in,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic       so_in,
    output logic       si_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int               c_div_w    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int               c_to_w     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT - 1);
    localparam logic [2:0]         c_last_bit = 3'(LINK_BITS - 1);

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic w_sck_s;
    logic w_so_s;

    sync2 #(.RESET_VAL(1'b1)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .d     (sck_in),
        .q     (w_sck_s)
    );

    sync2 #(.RESET_VAL(1'b1)) u_sync_so (
        .clk   (clk),
        .reset (reset),
        .d     (so_in),
        .q     (w_so_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    link_state_t        r_state;
    logic               r_mode_master;   // mode latched when leaving IDLE
    logic [2:0]         r_bit_cnt;
    link_byte_t         r_buf;
    logic               r_buf_full;
    link_byte_t         r_tx_sh;
    logic [6:0]         r_rx_sh;
    link_byte_t         r_rx_data;
    logic               r_rx_valid;
    logic               r_sck_out;
    logic               r_sck_prev;
    logic [c_div_w-1:0] r_div;
    logic [c_to_w-1:0]  r_to;

    // Slave edges come from the synchronized SCK.
    logic w_s_rise;
    logic w_s_fall;
    assign w_s_rise = w_sck_s & ~r_sck_prev;
    assign w_s_fall = ~w_sck_s & r_sck_prev;

    // Master edges are the toggles of the generated SCK, taken on the same
    // clk edge that changes sck_out so no synchronizer delay is added.
    logic w_tick;
    logic w_m_rise;
    logic w_m_fall;
    assign w_tick   = (r_state == ST_SHIFT) && r_mode_master && (r_div == c_div_last);
    assign w_m_rise = w_tick & ~r_sck_out;
    assign w_m_fall = w_tick & r_sck_out;

    logic w_rise;
    logic w_fall;
    assign w_rise = (r_state == ST_SHIFT) && (r_mode_master ? w_m_rise : w_s_rise);
    assign w_fall = (r_state == ST_SHIFT) && (r_mode_master ? w_m_fall : w_s_fall);

    link_byte_t w_rx_next;
    link_byte_t w_load_byte;
    assign w_rx_next   = {r_rx_sh, w_so_s};
    assign w_load_byte = r_buf_full ? r_buf : IDLE_BYTE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mode_master <= 1'b0;
            r_bit_cnt     <= 3'd0;
            r_buf         <= 8'h00;
            r_buf_full    <= 1'b0;
            r_tx_sh       <= IDLE_BYTE;
            r_rx_sh       <= 7'd0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_sck_out     <= 1'b1;
            r_sck_prev    <= 1'b1;
            r_div         <= '0;
            r_to          <= '0;
        end else begin
            r_sck_prev <= w_sck_s;
            r_rx_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= 3'd0;
                    r_div     <= '0;
                    r_to      <= '0;
                    r_sck_out <= 1'b1;
                    if (master) begin
                        // Master only starts with real data to send.
                        if (r_buf_full) begin
                            r_state       <= ST_SHIFT;
                            r_mode_master <= 1'b1;
                            r_tx_sh       <= r_buf;
                            r_buf_full    <= 1'b0;
                        end
                    end else if (w_s_fall) begin
                        // First DMG falling edge: current si_out level is
                        // already bit 7 of the byte being latched.
                        r_state       <= ST_SHIFT;
                        r_mode_master <= 1'b0;
                        r_tx_sh       <= w_load_byte;
                        r_buf_full    <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (r_mode_master) begin
                        if (w_tick) begin
                            r_div     <= '0;
                            r_sck_out <= ~r_sck_out;
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end else begin
                        if (w_s_rise || w_s_fall) begin
                            r_to <= '0;
                        end else if (r_to == c_to_last) begin
                            // Stalled DMG clock: drop the partial byte.
                            r_state   <= ST_IDLE;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_to <= r_to + 1'b1;
                        end
                    end

                    // The master's first fall precedes any rise and must not
                    // advance past bit 7; in slave mode that fall happened
                    // in IDLE, so the bit count tells the two apart.
                    if (w_fall && (r_bit_cnt != 3'd0)) begin
                        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                    end

                    if (w_rise) begin
                        r_rx_sh <= w_rx_next[6:0];
                        if (r_bit_cnt == c_last_bit) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_bit_cnt  <= 3'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Buffer fill may occur in any state; a load in the same cycle
            // only ever happens with the buffer already drained.
            if (tx_valid && !r_buf_full) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (r_state == ST_SHIFT);
    assign sck_oe   = busy & r_mode_master;
    assign sck_out  = r_sck_out;
    assign si_out   = busy ? r_tx_sh[7] : (r_buf_full ? r_buf[7] : IDLE_BYTE[7]);
    assign tx_ready = ~r_buf_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_link_partner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_link_partner
//  Description : Self-checking bench for link_partner. Plays the DMG side in
//                slave mode, observes the generated clock in master mode and
//                compares every exchanged byte against a queue-based model of
//                the one-entry tx buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_link_partner;

    localparam int         CLK_DIV   = 4;
    localparam int         TIMEOUT   = 4096;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       master   = 1'b0;
    logic       sck_in   = 1'b1;
    logic       so_in    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       sck_out;
    logic       sck_oe;
    logic       si_out;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    link_partner #(
        .CLK_DIV   (CLK_DIV),
        .IDLE_BYTE (IDLE_BYTE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .master   (master),
        .sck_in   (sck_in),
        .sck_out  (sck_out),
        .sck_oe   (sck_oe),
        .so_in    (so_in),
        .si_out   (si_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp      = 0;
    int n_fail     = 0;
    int rx_pulses  = 0;
    int exp_pulses = 0;

    // Model of the tx buffer contents in send order.
    logic [7:0] q[$];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int guard;
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 1000) begin
            cyc(1);
            guard++;
        end
        chk("push_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        q.push_back(b);
    endtask

    // DMG side: nbits falling/rising SCK pairs; captures si_out before each
    // rising edge. Optionally offers a tx byte during the low phase of one bit.
    task automatic slave_xfer(input logic [7:0] dmg, input int hp, input int nbits,
                              input int push_at, input logic [7:0] push_b,
                              output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sck_in = 1'b0;
            so_in  = dmg[7-i];
            cyc(hp);
            if (i == push_at) begin
                chk("mid_ready", tx_ready, 1);
                tx_data  = push_b;
                tx_valid = 1'b1;
                cyc(1);
                tx_valid = 1'b0;
                chk("mid_taken", tx_ready, 0);
                q.push_back(push_b);
            end
            got    = {got[6:0], si_out};
            sck_in = 1'b1;
            if (i < nbits - 1) cyc(hp);
        end
    endtask

    task automatic full_slave(input string tag, input logic [7:0] dmg, input int hp,
                              input int push_at, input logic [7:0] push_b);
        logic [7:0] exp_tx;
        logic [7:0] got;
        if (q.size() > 0) exp_tx = q.pop_front();
        else              exp_tx = IDLE_BYTE;
        chk({tag, "_idle_si"}, si_out, exp_tx[7]);
        slave_xfer(dmg, hp, 8, push_at, push_b, got);
        chk({tag, "_si_bits"}, got, exp_tx);
        cyc(2);
        chk({tag, "_rx_early"}, rx_valid, 0);
        cyc(1);
        chk({tag, "_rx_valid"}, rx_valid, 1);
        chk({tag, "_rx_data"}, rx_data, dmg);
        cyc(1);
        chk({tag, "_rx_once"}, rx_valid, 0);
        chk({tag, "_busy_end"}, busy, 0);
        exp_pulses++;
        cyc(hp);
    endtask

    task automatic master_xfer(input string tag, input logic [7:0] tx, input logic [7:0] so_byte,
                               input int flip_at);
        logic [7:0] exp_tx;
        logic [7:0] sent;
        logic [7:0] rxd;
        logic       prev;
        logic       si_last;
        logic       started;
        logic       oe_bad;
        logic       per_bad;
        int         busy_cyc, falls, rises, rxp, ntog, t0, last_t;
        sent = 8'h00; rxd = 8'h00; si_last = 1'b0; started = 1'b0;
        oe_bad = 1'b0; per_bad = 1'b0;
        busy_cyc = 0; falls = 0; rises = 0; rxp = 0; ntog = 0; t0 = 0; last_t = 0;
        master = 1'b1;
        push(tx);
        exp_tx = q.pop_front();
        prev   = sck_out;
        for (int t = 0; t < 40 * CLK_DIV; t++) begin
            cyc(1);
            if (busy === 1'b1) begin
                if (!started) t0 = t;
                started = 1'b1;
                busy_cyc++;
            end
            if (sck_oe !== busy) oe_bad = 1'b1;
            if (prev !== sck_out) begin
                if (ntog == 0) begin
                    if (t - t0 != CLK_DIV) per_bad = 1'b1;
                end else if (t - last_t != CLK_DIV) begin
                    per_bad = 1'b1;
                end
                last_t = t;
                ntog++;
            end
            if (prev === 1'b1 && sck_out === 1'b0) begin
                if (falls < 8) so_in = so_byte[7-falls];
                falls++;
            end
            if (prev === 1'b0 && sck_out === 1'b1) begin
                sent = {sent[6:0], si_last};
                rises++;
            end
            if (sck_out === 1'b0) si_last = si_out;
            if (rx_valid === 1'b1) begin
                rxp++;
                rxd = rx_data;
            end
            if (t == flip_at) master = 1'b0;
            prev = sck_out;
            if (started && busy !== 1'b1) break;
        end
        chk({tag, "_busy_cycles"}, busy_cyc, 16 * CLK_DIV);
        chk({tag, "_falls"}, falls, 8);
        chk({tag, "_rises"}, rises, 8);
        chk({tag, "_half_period"}, per_bad, 0);
        chk({tag, "_sck_oe"}, oe_bad, 0);
        chk({tag, "_si_bits"}, sent, exp_tx);
        chk({tag, "_rx_pulses"}, rxp, 1);
        chk({tag, "_rx_data"}, rxd, so_byte);
        cyc(1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_ready_after"}, tx_ready, 1);
        chk({tag, "_oe_after"}, sck_oe, 0);
        chk({tag, "_sck_idle"}, sck_out, 1);
        exp_pulses++;
        master = 1'b0;
        so_in  = 1'b1;
        cyc(4);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sck_oe"}, sck_oe, 0);
        chk({tag, "_sck_out"}, sck_out, 1);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_tx_ready"}, tx_ready, 1);
        chk({tag, "_si_out"}, si_out, IDLE_BYTE[7]);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] d;
        logic [7:0] got;
        logic [7:0] exp_tx;

        // Reset state
        reset = 1'b1;
        cyc(3);
        chk_reset_vals("reset");
        reset = 1'b0;
        cyc(2);

        // Buffered byte against a slow DMG clock
        push(8'hA5);
        chk("a5_idle_si_bit7", si_out, 1);
        full_slave("a5_3c", 8'h3C, 200, -1, 8'h00);

        // Empty buffer: the idle byte goes out
        full_slave("idle_00", 8'h00, 20, -1, 8'h00);

        // Randomized slave transfers, buffer randomly filled
        for (int n = 0; n < 5; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                push(b);
            end
            d = 8'($urandom);
            full_slave("rand_slave", d, int'($urandom_range(8, 40)), -1, 8'h00);
        end

        // Stalled SCK after 3 bits: abort without a strobe
        b = 8'($urandom);
        push(b);
        exp_tx = q.pop_front();
        d = 8'($urandom);
        slave_xfer(d, 20, 3, -1, 8'h00, got);
        chk("to_first_bits", got, {5'b00000, exp_tx[7:5]});
        cyc(5000);
        chk("to_busy", busy, 0);
        chk("to_no_rx", rx_pulses, exp_pulses);
        chk("to_ready", tx_ready, 1);
        full_slave("after_to", 8'($urandom), 16, -1, 8'h00);

        // Reset in the middle of a transfer
        push(8'($urandom));
        exp_tx = q.pop_front();
        slave_xfer(8'($urandom), 12, 5, -1, 8'h00, got);
        chk("rst_first_bits", got, {3'b000, exp_tx[7:3]});
        cyc(4);
        reset = 1'b1;
        cyc(1);
        chk_reset_vals("mid_reset");
        reset = 1'b0;
        q.delete();
        cyc(20);
        chk("rst_no_rx", rx_pulses, exp_pulses);

        // Byte offered while shifting is held for the next transfer
        b = 8'($urandom);
        full_slave("mid_push", 8'($urandom), 16, 2, b);
        chk("held_bit7", si_out, b[7]);
        full_slave("held_send", 8'($urandom), 16, -1, 8'h00);

        // Master mode
        master_xfer("m81", 8'h81, 8'h00, -1);
        master_xfer("mrand", 8'($urandom), 8'($urandom), 20);

        // Slave again after master
        full_slave("post_master", 8'($urandom), 16, -1, 8'h00);

        chk("total_rx_pulses", rx_pulses, exp_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
